// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave exposing a 16 x 8-bit register file.
//
// A write transfer loads a 4-bit register pointer from the first data byte.
// Each later byte is written to regs[ptr], after which the pointer
// auto-increments. A read transfer streams regs[ptr] onwards, also with
// auto-increment. SCL is only observed and is never stretched.
//
// Ports:
//   wb_clk_i       - sole clock, rising edge
//   arst_i         - asynchronous active-low reset
//   scl_pad_i      - SCL bus line (asynchronous, input only)
//   sda_pad_i      - SDA bus line (asynchronous)
//   sda_pad_o      - SDA drive value, tied low (open drain)
//   sda_padoen_o   - SDA output enable, active low
//   reg_adr_i      - local read-back index
//   reg_dat_o      - regs[reg_adr_i], combinational
//   wr_stb_o       - one-cycle pulse when an I2C write commits a register
//   wr_adr_o       - register index written on wr_stb_o
//   busy_o         - high from START until the next STOP
//
// Build option: define I2C_SLAVE_GLITCH_FILTER_EN to insert a FILT_DEPTH-sample
// glitch filter after the synchronizers. Without it the synchronized lines are
// used directly.

module i2c_slave_regfile #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h2,
    parameter int unsigned FILT_DEPTH = 3
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    output logic       sda_pad_o,
    output logic       sda_padoen_o,
    input  logic [3:0] reg_adr_i,
    output logic [7:0] reg_dat_o,
    output logic       wr_stb_o,
    output logic [3:0] wr_adr_o,
    output logic       busy_o
);

    // ------------------------------------------------------------------
    // Two-flop synchronizers; bus idles high, so they reset to 1
    // ------------------------------------------------------------------
    logic scl_meta_q, scl_sync_q, sda_meta_q, sda_sync_q;

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_pad_i;
            scl_sync_q <= scl_meta_q;
            sda_meta_q <= sda_pad_i;
            sda_sync_q <= sda_meta_q;
        end
    end

    logic scl_f, sda_f;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int unsigned CntW = (FILT_DEPTH > 1) ? $clog2(FILT_DEPTH) : 1;

    logic [CntW-1:0] scl_cnt_q, sda_cnt_q;
    logic            scl_filt_q, sda_filt_q;

    // A filtered line flips only after FILT_DEPTH consecutive samples that
    // disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            if (scl_sync_q == scl_filt_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CntW'(FILT_DEPTH - 1)) begin
                scl_filt_q <= scl_sync_q;
                scl_cnt_q  <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 1'b1;
            end

            if (sda_sync_q == sda_filt_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == CntW'(FILT_DEPTH - 1)) begin
                sda_filt_q <= sda_sync_q;
                sda_cnt_q  <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 1'b1;
            end
        end
    end

    assign scl_f = scl_filt_q;
    assign sda_f = sda_filt_q;
`else
    logic unused_filt_depth;

    assign unused_filt_depth = ^FILT_DEPTH;
    assign scl_f = scl_sync_q;
    assign sda_f = sda_sync_q;
`endif

    // ------------------------------------------------------------------
    // Edge and bus-condition detection on the conditioned lines
    // ------------------------------------------------------------------
    logic scl_prev_q, sda_prev_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

    // ------------------------------------------------------------------
    // Protocol FSM, register file and registered outputs
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck
    } state_e;

    state_e     state_q;
    logic [7:0] regs_q [16];
    logic [3:0] ptr_q;
    logic [7:0] shift_q;
    logic [3:0] bit_cnt_q;
    logic       sda_oen_q;
    logic       wr_stb_q;
    logic [3:0] wr_adr_q;
    logic       busy_q;
    logic [7:0] rd_byte;
    logic       byte_done;

    assign rd_byte   = regs_q[ptr_q];
    // Eighth bit has been clocked in and SCL has just gone low again
    assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q   <= StIdle;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 8'h00;
            end
            ptr_q     <= 4'd0;
            shift_q   <= 8'h00;
            bit_cnt_q <= 4'd0;
            sda_oen_q <= 1'b1;
            wr_stb_q  <= 1'b0;
            wr_adr_q  <= 4'd0;
            busy_q    <= 1'b0;
        end else begin
            wr_stb_q <= 1'b0;
            if (start_det) begin
                // START and repeated START both abandon any byte in flight
                state_q   <= StAddr;
                bit_cnt_q <= 4'd0;
                sda_oen_q <= 1'b1;
                busy_q    <= 1'b1;
            end else if (stop_det) begin
                state_q   <= StIdle;
                bit_cnt_q <= 4'd0;
                sda_oen_q <= 1'b1;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // Also the hold state after a NACK or foreign address
                    end
                    StAddr: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_f};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt_q <= 4'd0;
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                state_q   <= StAddrAck;
                                sda_oen_q <= 1'b0;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            bit_cnt_q <= 4'd0;
                            if (shift_q[0]) begin
                                // Read: put the MSB on the bus before SCL rises
                                state_q   <= StRdata;
                                shift_q   <= rd_byte;
                                sda_oen_q <= rd_byte[7];
                                ptr_q     <= ptr_q + 4'd1;
                            end else begin
                                state_q   <= StPtr;
                                sda_oen_q <= 1'b1;
                            end
                        end
                    end
                    StPtr: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_f};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt_q <= 4'd0;
                            ptr_q     <= shift_q[3:0];
                            state_q   <= StPtrAck;
                            sda_oen_q <= 1'b0;
                        end
                    end
                    StPtrAck: begin
                        if (scl_fall) begin
                            state_q   <= StWdata;
                            sda_oen_q <= 1'b1;
                        end
                    end
                    StWdata: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_f};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt_q <= 4'd0;
                            state_q   <= StWdataAck;
                            sda_oen_q <= 1'b0;
                        end
                    end
                    StWdataAck: begin
                        // Commit as the ACK clock ends; pointer wraps 15 -> 0
                        if (scl_fall) begin
                            regs_q[ptr_q] <= shift_q;
                            wr_stb_q      <= 1'b1;
                            wr_adr_q      <= ptr_q;
                            ptr_q         <= ptr_q + 4'd1;
                            state_q       <= StWdata;
                            sda_oen_q     <= 1'b1;
                        end
                    end
                    StRdata: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                state_q   <= StRdataAck;
                                sda_oen_q <= 1'b1;
                                bit_cnt_q <= 4'd0;
                            end else begin
                                shift_q   <= {shift_q[6:0], 1'b0};
                                sda_oen_q <= shift_q[6];
                            end
                        end
                    end
                    StRdataAck: begin
                        // bit_cnt_q == 1 marks that the master ACKed
                        if (scl_rise) begin
                            if (sda_f) begin
                                state_q <= StIdle;
                            end else begin
                                bit_cnt_q <= 4'd1;
                            end
                        end else if (scl_fall && (bit_cnt_q == 4'd1)) begin
                            bit_cnt_q <= 4'd0;
                            state_q   <= StRdata;
                            shift_q   <= rd_byte;
                            sda_oen_q <= rd_byte[7];
                            ptr_q     <= ptr_q + 4'd1;
                        end
                    end
                    default: begin
                        state_q   <= StIdle;
                        sda_oen_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = sda_oen_q;
    assign reg_dat_o    = regs_q[reg_adr_i];
    assign wr_stb_o     = wr_stb_q;
    assign wr_adr_o     = wr_adr_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench for i2c_slave_regfile: a bit-banged I2C master, an
// open-drain SDA model and a transaction-level register-file model.

module tb_i2c_slave_regfile;

    localparam int Q = 10;  // clock cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       arst_n;
    logic       m_scl;
    logic       m_sda;
    logic       sda_line;
    logic [3:0] reg_adr;
    logic       sda_pad_o;
    logic       sda_padoen_o;
    logic [7:0] reg_dat;
    logic       wr_stb;
    logic [3:0] wr_adr;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_regs [16];
    int         m_ptr;
    int         exp_wr [$];

    // Observations from the DUT, only appended to by the monitor
    int got_wr [$];
    int wr_seen = 0;
    int drive_cnt = 0;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
        logic [3:0] exp_a0;
        logic [3:0] exp_a1;
        logic [7:0] exp_r0;
        logic [7:0] exp_r1;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    assign sda_line = m_sda & (sda_padoen_o | sda_pad_o);

    i2c_slave_regfile #(
        .SLAVE_ADDR(7'h2),
        .FILT_DEPTH(3)
    ) dut (
        .wb_clk_i    (clk),
        .arst_i      (arst_n),
        .scl_pad_i   (m_scl),
        .sda_pad_i   (sda_line),
        .sda_pad_o   (sda_pad_o),
        .sda_padoen_o(sda_padoen_o),
        .reg_adr_i   (reg_adr),
        .reg_dat_o   (reg_dat),
        .wr_stb_o    (wr_stb),
        .wr_adr_o    (wr_adr),
        .busy_o      (busy)
    );

    always @(posedge clk) begin
        if (wr_stb) got_wr.push_back(int'(wr_adr));
        if (!sda_padoen_o) drive_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b0; cyc(Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        m_sda = 1'b0; cyc(Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        m_sda = 1'b1; cyc(Q);
    endtask

    task automatic bit_out(input logic b);
        m_sda = b;    cyc(Q);
        m_scl = 1'b1; cyc(2 * Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic bit_in(output logic b);
        m_sda = 1'b1; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        b = sda_line; cyc(Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(b);
        ack = ~b;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(nack);
    endtask

    task automatic check_wr(input string tag);
        check({tag, " wr count"}, got_wr.size() - wr_seen, exp_wr.size());
        for (int i = 0; i < exp_wr.size() && wr_seen + i < got_wr.size(); i++)
            check($sformatf("%s wr_adr[%0d]", tag, i), got_wr[wr_seen + i], exp_wr[i]);
        wr_seen = got_wr.size();
        exp_wr.delete();
    endtask

    task automatic do_write(input logic [3:0] ptr, input int n, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] d2, input string tag);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        wr_byte(8'h04, ack);
        check({tag, " addr ack"}, ack, 1);
        wr_byte({4'h0, ptr}, ack);
        check({tag, " ptr ack"}, ack, 1);
        m_ptr = int'(ptr);
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
            wr_byte(d, ack);
            check($sformatf("%s data%0d ack", tag, k), ack, 1);
            m_regs[m_ptr] = d;
            exp_wr.push_back(m_ptr);
            m_ptr = (m_ptr + 1) % 16;
        end
        i2c_stop();
        check({tag, " busy after stop"}, busy, 0);
        check_wr(tag);
    endtask

    task automatic do_read(input logic set_ptr, input logic [3:0] ptr, input int n,
                           input string tag);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        if (set_ptr) begin
            wr_byte(8'h04, ack);
            check({tag, " waddr ack"}, ack, 1);
            wr_byte({4'h0, ptr}, ack);
            check({tag, " ptr ack"}, ack, 1);
            m_ptr = int'(ptr);
            i2c_rstart();
        end
        wr_byte(8'h05, ack);
        check({tag, " raddr ack"}, ack, 1);
        for (int k = 0; k < n; k++) begin
            rd_byte(k == n - 1, d);
            check($sformatf("%s rdata%0d", tag, k), d, m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % 16;
        end
        check({tag, " sda released after nack"}, sda_padoen_o, 1);
        i2c_stop();
        check({tag, " busy after stop"}, busy, 0);
        check_wr(tag);
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] d;
        int         kind;
        int         dc;

        vecs[0] = '{8'h04, 4'h3, 8'hA5, 8'h5A, 1'b1, 4'h3, 4'h4, 8'hA5, 8'h5A};
        vecs[1] = '{8'h06, 4'h1, 8'h99, 8'h98, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00};
        vecs[2] = '{8'h04, 4'hF, 8'h11, 8'h22, 1'b1, 4'hF, 4'h0, 8'h11, 8'h22};
        vecs[3] = '{8'h07, 4'h2, 8'h33, 8'h44, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00};
        vecs[4] = '{8'h04, 4'h8, 8'h00, 8'hFF, 1'b1, 4'h8, 4'h9, 8'h00, 8'hFF};

        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr   = 0;
        arst_n  = 1'b0;
        m_scl   = 1'b1;
        m_sda   = 1'b1;
        reg_adr = 4'd0;
        cyc(3);

        // Reset state
        check("rst sda_padoen_o", sda_padoen_o, 1);
        check("rst sda_pad_o", sda_pad_o, 0);
        check("rst wr_stb_o", wr_stb, 0);
        check("rst wr_adr_o", wr_adr, 0);
        check("rst busy_o", busy, 0);
        check("rst reg_dat_o", reg_dat, 0);
        arst_n = 1'b1;
        cyc(Q);

        // Reset in the middle of a read while the slave drives a 0 data bit
        i2c_start();
        check("busy after start", busy, 1);
        wr_byte(8'h05, ack);
        check("rstmid raddr ack", ack, 1);
        bit_in(b);
        bit_in(b);
        m_sda = 1'b1; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        check("rstmid slave driving bit3", sda_padoen_o, 0);
        arst_n = 1'b0;
        #1;
        check("rstmid sda released", sda_padoen_o, 1);
        cyc(3);
        arst_n = 1'b1;
        cyc(Q);
        check("rstmid busy after reset", busy, 0);
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        do_write(4'h0, 1, 8'h77, 8'h00, 8'h00, "rstmid write");
        reg_adr = 4'h0;
        #1;
        check("rstmid regs[0]", reg_dat, 8'h77);

        // Table-driven write transfers, including foreign addresses
        for (int v = 0; v < 5; v++) begin
            dc = drive_cnt;
            i2c_start();
            wr_byte(vecs[v].addr, ack);
            check($sformatf("vec%0d addr ack", v), ack, vecs[v].exp_ack);
            if (vecs[v].exp_ack) begin
                wr_byte({4'h0, vecs[v].ptr}, ack);
                check($sformatf("vec%0d ptr ack", v), ack, 1);
                wr_byte(vecs[v].d0, ack);
                check($sformatf("vec%0d d0 ack", v), ack, 1);
                wr_byte(vecs[v].d1, ack);
                check($sformatf("vec%0d d1 ack", v), ack, 1);
                m_regs[vecs[v].ptr] = vecs[v].d0;
                m_regs[(int'(vecs[v].ptr) + 1) % 16] = vecs[v].d1;
                m_ptr = (int'(vecs[v].ptr) + 2) % 16;
                exp_wr.push_back(int'(vecs[v].exp_a0));
                exp_wr.push_back(int'(vecs[v].exp_a1));
            end else begin
                check($sformatf("vec%0d busy before stop", v), busy, 1);
                check($sformatf("vec%0d sda never driven", v), drive_cnt - dc, 0);
            end
            i2c_stop();
            check($sformatf("vec%0d busy after stop", v), busy, 0);
            check_wr($sformatf("vec%0d", v));
            if (vecs[v].exp_ack) begin
                reg_adr = vecs[v].exp_a0;
                #1;
                check($sformatf("vec%0d reg a0", v), reg_dat, vecs[v].exp_r0);
                reg_adr = vecs[v].exp_a1;
                #1;
                check($sformatf("vec%0d reg a1", v), reg_dat, vecs[v].exp_r1);
            end
        end

        // Read across the pointer wrap: regs[15] then regs[0], ACK then NACK
        do_read(1'b1, 4'hF, 2, "wrap read");

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // One-cycle SDA low pulse with SCL high must not look like a START
        @(posedge clk); #1;
        m_sda = 1'b0;
        @(posedge clk); #1;
        m_sda = 1'b1;
        cyc(3 * Q);
        check("glitch no start", busy, 0);
        do_write(4'h5, 1, 8'h3C, 8'h00, 8'h00, "after glitch");
`endif

        // Randomized transfers checked against the model
        for (int r = 0; r < 6; r++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                do_write(4'($urandom_range(0, 15)), $urandom_range(1, 3), 8'($urandom),
                         8'($urandom), 8'($urandom), $sformatf("rnd%0d write", r));
            end else if (kind == 1) begin
                do_read(1'b1, 4'($urandom_range(0, 15)), $urandom_range(1, 3),
                        $sformatf("rnd%0d setread", r));
            end else begin
                do_read(1'b0, 4'h0, $urandom_range(1, 3), $sformatf("rnd%0d read", r));
            end
        end

        // Final register-file contents against the model
        for (int a = 0; a < 16; a++) begin
            reg_adr = 4'(a);
            #1;
            check($sformatf("final regs[%0d]", a), reg_dat, m_regs[a]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regfile.md
I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h2, the 7-bit I2C address this slave answers.
REQ-002 SHALL have parameter FILT_DEPTH, default 3, the number of agreeing samples required by the glitch filter (used only when the filter is compiled in).
REQ-003 SHALL have port wb_clk_i, input, 1, the only clock (all logic on its rising edge).
REQ-004 SHALL have port arst_i, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port scl_pad_i, input, 1, the SCL bus line; it is asynchronous and is never driven by this block.
REQ-006 SHALL have port sda_pad_i, input, 1, the SDA bus line; it is asynchronous.
REQ-007 SHALL have port sda_pad_o, output, 1, SDA drive value, constant 1'b0.
REQ-008 SHALL have port sda_padoen_o, output, 1, SDA output enable, active low.
REQ-009 SHALL have port reg_adr_i, input, 4, the local read-back index.
REQ-010 SHALL have port reg_dat_o, output, 8, the register selected by reg_adr_i, combinational.
REQ-011 SHALL have port wr_stb_o, output, 1, a one-cycle pulse when an I2C write commits to a register.
REQ-012 SHALL have port wr_adr_o, output, 4, the index written on wr_stb_o.
REQ-013 SHALL have port busy_o, output, 1, high from a START until the next STOP.

Function
REQ-014 SHALL synchronize scl_pad_i and sda_pad_i through 2 flops before any use; all edge and condition detection uses the synchronized values.
REQ-015 SHALL detect START (SDA falls while SCL is high), repeated START, and STOP (SDA rises while SCL is high) in any state.
REQ-016 SHALL implement the states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-017 SHALL go to ADDR on START or repeated START; SHALL shift 8 bits MSB first on SCL rising edges.
REQ-018 SHALL compare the address byte [7:1] with SLAVE_ADDR.
  - Mismatch: return to IDLE without driving SDA.
  - Match: go to ADDR_ACK.
REQ-019 SHALL drive ACK by asserting sda_padoen_o=0 on the SCL falling edge after bit 8, and release it on the next SCL falling edge.
REQ-020 After an ADDR_ACK with R/W=0, SHALL go to PTR; the first byte loads the 4-bit pointer from byte[3:0] and is ACKed (PTR_ACK). Subsequent bytes go through WDATA/WDATA_ACK.
REQ-021 In WDATA_ACK, SHALL write the byte to regs[ptr], pulse wr_stb_o with wr_adr_o=ptr, then increment ptr modulo 16 (15 wraps to 0).
REQ-022 After an ADDR_ACK with R/W=1, SHALL go to RDATA.
  - Loads regs[ptr] into the shift register and presents its MSB on SDA before the first SCL rise (drives 0 via sda_padoen_o=0, releases for 1).
  - ptr increments modulo 16 after each byte.
REQ-023 In RDATA_ACK, SHALL sample the master's bit on SCL rising.
  - ACK (0): continue with RDATA.
  - NACK (1): release SDA and wait in IDLE-like hold for STOP/START.
REQ-024 SHALL abort the current byte on STOP (go to IDLE) or on repeated START (go to ADDR), retain ptr and register contents, and release SDA within 1 cycle.
REQ-025 SHALL assert busy_o on START and clear it on STOP.
REQ-026 SHALL never stretch SCL.

Reset
REQ-027 On arst_i=0, SHALL asynchronously set:
  - state=IDLE
  - sda_padoen_o=1, sda_pad_o=0
  - wr_stb_o=0, wr_adr_o=0, busy_o=0
  - ptr=0, all 16 registers=8'h00
  - synchronizer and filter flops=1
REQ-028 Reset mid-transfer SHALL release SDA immediately; after release, the block SHALL wait for a fresh START.

Configuration
REQ-029 Macro I2C_SLAVE_GLITCH_FILTER_EN.
  - Defined: a filtered line SHALL change only after FILT_DEPTH consecutive identical synchronized samples, adding FILT_DEPTH cycles of latency.
  - Undefined: the synchronized lines are used directly, and FILT_DEPTH is ignored.

Verification
REQ-030 Write transfer: START, 0x04, 0x03, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; regs[3]=0xA5 and regs[4]=0x5A; two wr_stb_o pulses with wr_adr_o 3 then 4.
REQ-031 Read transfer: START, 0x04, 0x0F, repeated START, 0x05, read 2 bytes (ACK, then NACK), STOP -> data regs[15] then regs[0] (pointer wrap); SDA released after the NACK.
REQ-032 Address mismatch: START, 0x06 -> SDA never driven; busy_o=1 until STOP; no wr_stb_o.
REQ-033 Reset mid-read: arst_i low while the slave drives 0 in bit 3 -> sda_padoen_o=1 in the same timestep; a later write to regs[0] succeeds.
REQ-034 With I2C_SLAVE_GLITCH_FILTER_EN: a 1-cycle SDA low pulse while SCL is high -> no START detected, state stays IDLE.
